// File: rtl/timer_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : timer_pkg
// Brief    : Shared types, defaults and helpers for the timer scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package timer_pkg;

   // Width of the shared SyncCounter instance.
   localparam int CW_DEFAULT = 20;

   // IDLE: nothing armed, counter held clear. RUN: at least one deadline pending.
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // A zero delay would equal the current count and never fire, so clamp it to 1.
   function automatic logic [31:0] max1(input logic [31:0] d);
      return (d == 32'd0) ? 32'd1 : d;
   endfunction

endpackage
`default_nettype wire

// File: rtl/timer_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : One-hot round-robin arbiter; the pointer moves past each winner.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         clr,
   input  logic [N-1:0] elig,
   input  logic         adv,
   output logic [N-1:0] grant
);

   localparam int PTRW = (N > 1) ? $clog2(N) : 1;

   logic [PTRW-1:0] r_ptr;
   logic [PTRW-1:0] w_next_ptr;
   logic [PTRW-1:0] w_idx;
   logic            w_found;
   int              w_sum;

   // Scan from the pointer upward (wrapping) and take the first eligible channel.
   always_comb begin
      grant      = '0;
      w_next_ptr = r_ptr;
      w_found    = 1'b0;
      w_sum      = 0;
      w_idx      = '0;
      for (int k = 0; k < N; k++) begin
         w_sum = int'(r_ptr) + k;
         if (w_sum >= N) w_sum = w_sum - N;
         w_idx = PTRW'(w_sum);
         if (!w_found && elig[w_idx]) begin
            w_found      = 1'b1;
            grant[w_idx] = 1'b1;
            w_next_ptr   = (w_sum == N - 1) ? '0 : PTRW'(w_sum + 1);
         end
      end
   end

   // Pointer advances only when a grant is actually taken.
   always_ff @(posedge clk) begin
      if (clr) r_ptr <= '0;
      else if (adv && w_found) r_ptr <= w_next_ptr;
   end

endmodule
`default_nettype wire

// File: rtl/timer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : timer_scheduler
// Brief    : Shares one tick counter between NCH one-shot alarm channels:
//            prescaler, round-robin arm arbitration, deadline compare.
// Revision : 1.0 - initial release
// ============================================================================
module timer_scheduler
   import timer_pkg::*;
#(
   parameter int NCH = 4,
   parameter int CW  = CW_DEFAULT,
   parameter int PW  = 8
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              tick_en,
   input  logic [PW-1:0]     prescale,
   input  logic [NCH-1:0]    req,
   input  logic [NCH*CW-1:0] req_delay,
   input  logic [NCH-1:0]    cancel,
   output logic [NCH-1:0]    ack,
   output logic [NCH-1:0]    armed,
   output logic [NCH-1:0]    wakeup,
   output logic              cnt_en,
   output logic              cnt_clr,
   input  logic [CW-1:0]     cnt_val
);

   state_t          r_state;
   state_t          w_state_next;
   logic [PW-1:0]   r_presc;
   logic            w_terminal;
   logic [NCH-1:0]  w_elig;
   logic [NCH-1:0]  w_grant;
   logic [NCH-1:0]  w_hit;
   logic [NCH-1:0]  w_armed_next;
   logic [CW-1:0]   w_base;

   // Armed channels ignore further requests until they disarm.
   assign w_elig = req & ~armed;

   rr_arbiter #(.N(NCH)) u_arb (
      .clk   (clk),
      .clr   (clr),
      .elig  (w_elig),
      .adv   (|w_elig),
      .grant (w_grant)
   );

   // In IDLE the counter is being cleared at this edge, so deadlines start at 0.
   assign w_base = (r_state == IDLE) ? '0 : cnt_val;

   generate
      for (genvar i = 0; i < NCH; i++) begin : g_ch
         logic [CW-1:0] w_delay;
         logic [CW-1:0] r_dl;

         assign w_delay  = req_delay[i*CW +: CW];
         assign w_hit[i] = armed[i] && (cnt_val == r_dl);

         // Capture the absolute (wrapping) deadline when this channel is granted.
         always_ff @(posedge clk) begin
            if (clr) r_dl <= '0;
            else if (w_grant[i]) r_dl <= w_base + CW'(max1(32'(w_delay)));
         end
      end
   endgenerate

   // Fire and cancel both disarm; a fresh grant only ever lands on an unarmed channel.
   assign w_armed_next = (armed & ~cancel & ~w_hit) | w_grant;

   // Terminal compare uses >= so a prescale reduced mid-count still wraps.
   assign w_terminal = (r_presc >= prescale);

   // State register.
   always_ff @(posedge clk) begin
      if (clr) r_state <= IDLE;
      else     r_state <= w_state_next;
   end

   // Next-state and counter control.
   always_comb begin
      w_state_next = r_state;
      cnt_clr      = 1'b1;
      cnt_en       = 1'b0;
      case (r_state)
         IDLE: begin
            cnt_clr = 1'b1;
            if (|w_grant) w_state_next = RUN;
         end
         RUN: begin
            cnt_clr = 1'b0;
            cnt_en  = tick_en && w_terminal;
            if ((w_armed_next == '0) && (w_grant == '0)) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Prescaler: held at 0 in IDLE, frozen while tick_en is low.
   always_ff @(posedge clk) begin
      if (clr || (r_state == IDLE)) r_presc <= '0;
      else if (tick_en)             r_presc <= w_terminal ? '0 : r_presc + 1'b1;
   end

   // Registered per-channel outputs; cancel suppresses a coincident fire.
   always_ff @(posedge clk) begin
      if (clr) begin
         ack    <= '0;
         armed  <= '0;
         wakeup <= '0;
      end else begin
         ack    <= w_grant;
         armed  <= w_armed_next;
         wakeup <= w_hit & ~cancel;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_timer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_scheduler
// Brief    : Self-checking bench: directed tables/sequences plus random traffic
//            against a cycle-level behavioural model of the scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_timer_scheduler;

   localparam int          NCH = 4;
   localparam int          CW  = 20;
   localparam int          PW  = 8;
   localparam int unsigned MOD = 32'd1 << CW;

   logic              clk = 1'b0;
   logic              clr, tick_en, cnt_en, cnt_clr, ld;
   logic [PW-1:0]     prescale;
   logic [NCH-1:0]    req, cancel, ack, armed, wakeup;
   logic [NCH*CW-1:0] req_delay;
   logic [CW-1:0]     cnt_val, ld_val;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_on   = 1'b0;

   always #5 clk = ~clk;

   timer_scheduler #(.NCH(NCH), .CW(CW), .PW(PW)) dut (
      .clk(clk), .clr(clr), .tick_en(tick_en), .prescale(prescale),
      .req(req), .req_delay(req_delay), .cancel(cancel),
      .ack(ack), .armed(armed), .wakeup(wakeup),
      .cnt_en(cnt_en), .cnt_clr(cnt_clr), .cnt_val(cnt_val)
   );

   // SyncCounter stand-in, with a bench-only preload to reach the wrap point quickly.
   always @(posedge clk) begin
      if (ld)           cnt_val <= ld_val;
      else if (cnt_clr) cnt_val <= '0;
      else if (cnt_en)  cnt_val <= cnt_val + 1'b1;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   logic [NCH-1:0] m_ack = '0, m_armed = '0, m_wake = '0;
   bit             m_run = 1'b0;
   int             m_ptr = 0;
   int unsigned    m_presc = 0, m_cnt = 0;
   int unsigned    m_dl [NCH];

   always @(posedge clk) begin
      int          g, ci, dd;
      int unsigned c_old;
      bit          en;
      c_old = m_cnt;
      en    = m_run && tick_en && (m_presc >= int'(prescale));
      if (ld)          m_cnt = int'(ld_val);
      else if (!m_run) m_cnt = 0;
      else if (en)     m_cnt = (m_cnt + 1) % MOD;
      if (clr) begin
         m_ack = '0; m_armed = '0; m_wake = '0; m_run = 1'b0; m_ptr = 0; m_presc = 0;
      end else begin
         g = -1;
         for (int k = 0; k < NCH; k++) begin
            ci = (m_ptr + k) % NCH;
            if (g < 0 && req[ci] && !m_armed[ci]) g = ci;
         end
         m_ack  = '0;
         m_wake = '0;
         for (int i = 0; i < NCH; i++) begin
            if (m_armed[i] && c_old == m_dl[i]) begin
               m_wake[i]  = !cancel[i];
               m_armed[i] = 1'b0;
            end
            if (cancel[i]) m_armed[i] = 1'b0;
         end
         if (g >= 0) begin
            dd         = int'(req_delay[g*CW +: CW]);
            if (dd == 0) dd = 1;
            m_dl[g]    = ((m_run ? c_old : 0) + dd) % MOD;
            m_armed[g] = 1'b1;
            m_ack[g]   = 1'b1;
            m_ptr      = (g + 1) % NCH;
         end
         if (!m_run)       m_presc = 0;
         else if (tick_en) m_presc = en ? 0 : m_presc + 1;
         m_run = (m_armed != '0);
      end
   end

   // Every cycle: DUT outputs and counter against the model.
   always @(negedge clk) begin
      logic m_en;
      if (chk_on) begin
         m_en = m_run && tick_en && (m_presc >= int'(prescale));
         chk("cycle_outputs", 64'({ack, armed, wakeup, cnt_en, cnt_clr}),
             64'({m_ack, m_armed, m_wake, m_en, ~m_run}));
         chk("cycle_counter", 64'(cnt_val), 64'(m_cnt));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic nxt();
      @(negedge clk);
      #1;
   endtask

   task automatic set_delay(input int ch, input int d);
      req_delay[ch*CW +: CW] = CW'(d);
   endtask

   task automatic do_reset();
      clr = 1'b1; req = '0; cancel = '0; ld = 1'b0;
      nxt();
      clr = 1'b0;
   endtask

   // Raise req, wait for ack, drop req in the ack cycle.
   task automatic arm(input int ch, input int d, output int cyc);
      bit got;
      got = 1'b0; cyc = 0;
      set_delay(ch, d);
      req[ch] = 1'b1;
      for (int c = 0; c < 16 && !got; c++) begin
         nxt();
         cyc++;
         if (ack[ch]) got = 1'b1;
      end
      req[ch] = 1'b0;
      chk("arm_ack_seen", 64'(got), 64'(1));
   endtask

   // Observe a fixed window starting at the ack cycle (n=0).
   task automatic measure(input int ch, input int idle_cyc, output int lat, output int wakes,
                          output int en_cnt, output int first_en, output int prev_cnt);
      logic [CW-1:0] pc;
      lat = -1; wakes = 0; en_cnt = 0; first_en = -1; prev_cnt = -1;
      pc = cnt_val;
      for (int n = 0; n < 40; n++) begin
         tick_en = (n >= idle_cyc);
         #1;
         if (cnt_en) begin
            en_cnt++;
            if (first_en < 0) first_en = n;
         end
         if (wakeup[ch]) begin
            wakes++;
            if (lat < 0) begin lat = n; prev_cnt = int'(pc); end
         end
         pc = cnt_val;
         nxt();
      end
      tick_en = 1'b1;
   endtask

   typedef struct {
      logic [NCH-1:0] req;
      logic [NCH-1:0] cancel;
      logic [NCH-1:0] ack;
      logic [NCH-1:0] armed;
   } vec_t;

   vec_t tbl [18];

   initial begin
      int cyc, lat, wakes, en_cnt, first_en, prev_cnt, acc;

      tbl[0]  = '{4'b1111, 4'b0000, 4'b0001, 4'b0001};
      tbl[1]  = '{4'b1110, 4'b0000, 4'b0010, 4'b0011};
      tbl[2]  = '{4'b1100, 4'b0000, 4'b0100, 4'b0111};
      tbl[3]  = '{4'b1000, 4'b0000, 4'b1000, 4'b1111};
      tbl[4]  = '{4'b0000, 4'b0000, 4'b0000, 4'b1111};
      tbl[5]  = '{4'b0000, 4'b1111, 4'b0000, 4'b0000};
      tbl[6]  = '{4'b1111, 4'b0000, 4'b0001, 4'b0001};
      tbl[7]  = '{4'b1110, 4'b0000, 4'b0010, 4'b0011};
      tbl[8]  = '{4'b1100, 4'b0000, 4'b0100, 4'b0111};
      tbl[9]  = '{4'b1000, 4'b0000, 4'b1000, 4'b1111};
      tbl[10] = '{4'b0000, 4'b1111, 4'b0000, 4'b0000};
      tbl[11] = '{4'b0010, 4'b0000, 4'b0010, 4'b0010};
      tbl[12] = '{4'b0000, 4'b0010, 4'b0000, 4'b0000};
      tbl[13] = '{4'b1111, 4'b0000, 4'b0100, 4'b0100};
      tbl[14] = '{4'b1011, 4'b0000, 4'b1000, 4'b1100};
      tbl[15] = '{4'b0011, 4'b0000, 4'b0001, 4'b1101};
      tbl[16] = '{4'b0010, 4'b0000, 4'b0010, 4'b1111};
      tbl[17] = '{4'b0000, 4'b1111, 4'b0000, 4'b0000};

      clr = 1'b1; tick_en = 1'b1; prescale = '0; req = '0; cancel = '0;
      req_delay = '0; ld = 1'b0; ld_val = '0;
      repeat (3) nxt();
      clr = 1'b0;
      chk_on = 1'b1;
      chk("reset_outputs", 64'({ack, armed, wakeup, cnt_en, cnt_clr}), 64'(13'b0000_0000_0000_1));

      // Single arm from IDLE, delay 5.
      arm(0, 5, cyc);
      chk("t1_ack_latency", 64'(cyc), 64'(1));
      chk("t1_armed", 64'(armed), 64'(4'b0001));
      measure(0, 0, lat, wakes, en_cnt, first_en, prev_cnt);
      chk("t1_wake_count", 64'(wakes), 64'(1));
      chk("t1_wake_latency", 64'(lat), 64'(6));
      chk("t1_count_at_fire", 64'(prev_cnt), 64'(5));
      chk("t1_idle_clr", 64'(cnt_clr), 64'(1));

      // Round-robin burst table.
      do_reset();
      for (int c = 0; c < NCH; c++) set_delay(c, 100);
      for (int v = 0; v < 18; v++) begin
         req = tbl[v].req; cancel = tbl[v].cancel;
         nxt();
         chk($sformatf("rr_ack_%0d", v), 64'(ack), 64'(tbl[v].ack));
         chk($sformatf("rr_armed_%0d", v), 64'(armed), 64'(tbl[v].armed));
      end
      req = '0; cancel = '0;

      // Wrap-around: arm in RUN at 0xFFFFE with delay 4.
      do_reset();
      arm(3, 1000, cyc);
      tick_en = 1'b0; ld = 1'b1; ld_val = 20'hFFFFE;
      nxt();
      ld = 1'b0;
      chk("t3_preload", 64'(cnt_val), 64'(20'hFFFFE));
      arm(0, 4, cyc);
      measure(0, 0, lat, wakes, en_cnt, first_en, prev_cnt);
      chk("t3_wake_count", 64'(wakes), 64'(1));
      chk("t3_wake_latency", 64'(lat), 64'(5));
      chk("t3_count_at_fire", 64'(prev_cnt), 64'(2));
      cancel = 4'b1000; nxt(); cancel = '0;

      // Prescale 3, delay 2 from IDLE; then again with 10 cycles of tick_en low.
      do_reset();
      prescale = 8'd3;
      arm(0, 2, cyc);
      measure(0, 0, lat, wakes, en_cnt, first_en, prev_cnt);
      chk("t4_first_en", 64'(first_en), 64'(3));
      chk("t4_en_count", 64'(en_cnt), 64'(2));
      chk("t4_wake_latency", 64'(lat), 64'(9));
      arm(0, 2, cyc);
      measure(0, 10, lat, wakes, en_cnt, first_en, prev_cnt);
      chk("t4_stall_first_en", 64'(first_en), 64'(13));
      chk("t4_stall_latency", 64'(lat), 64'(19));
      chk("t4_stall_wakes", 64'(wakes), 64'(1));
      prescale = '0;

      // Cancel coincident with fire on ch1, delay 0 clamps... use delay 3.
      do_reset();
      arm(1, 3, cyc);
      nxt(); nxt(); nxt();
      chk("t5_count_at_cancel", 64'(cnt_val), 64'(3));
      cancel = 4'b0010;
      nxt();
      cancel = '0;
      chk("t5_no_wakeup", 64'(wakeup), 64'(0));
      chk("t5_disarmed", 64'(armed), 64'(0));
      chk("t5_clr_after_last", 64'(cnt_clr), 64'(1));
      acc = 0;
      repeat (8) begin nxt(); if (wakeup != '0) acc++; end
      chk("t5_quiet_after", 64'(acc), 64'(0));

      // Zero delay clamps to one tick.
      arm(2, 0, cyc);
      measure(2, 0, lat, wakes, en_cnt, first_en, prev_cnt);
      chk("t5_zero_delay_latency", 64'(lat), 64'(2));

      // Reset with three channels armed mid-count.
      do_reset();
      arm(0, 50, cyc); arm(1, 60, cyc); arm(2, 70, cyc);
      repeat (10) nxt();
      clr = 1'b1;
      nxt();
      clr = 1'b0;
      chk("t6_reset_outputs", 64'({ack, armed, wakeup, cnt_en, cnt_clr}), 64'(13'b0000_0000_0000_1));
      acc = 0;
      repeat (200) begin nxt(); if (wakeup != '0) acc++; end
      chk("t6_no_wakeups", 64'(acc), 64'(0));

      // Random traffic against the model.
      for (int seg = 0; seg < 4; seg++) begin
         do_reset();
         prescale = PW'(seg);
         for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NCH; i++) begin
               if (req[i] && ack[i]) req[i] = 1'b0;
               else if (!req[i] && $urandom_range(0, 7) == 0) begin
                  set_delay(i, ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 30)));
                  req[i] = 1'b1;
               end
               cancel[i] = ($urandom_range(0, 15) == 0);
            end
            tick_en = ($urandom_range(0, 7) != 0);
            nxt();
         end
         req = '0; cancel = '0; tick_en = 1'b1;
      end

      nxt();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
